rgb_ram_reader: RTL and testbench



---
 rtl/rgb_ram_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 88 ++++++++
 rtl/rgb_ram_reader.sv | 226 ++++++++++++++++++++++
 tb/tb_rgb_ram_reader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_ram_pkg.sv
// rgb_ram_pkg: shared definitions for the RGB RAM read path.
//   - reader FSM state encoding
//   - RAM geometry (ADDR_W, DATA_W)
//   - default substitute colour pushed on a response timeout
//   - next_addr(): modulo-256 address step
package rgb_ram_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 24;
  localparam int LEN_W  = ADDR_W + 1;

  localparam logic [DATA_W-1:0] ERR_COLOR_DEF = 24'hFF00FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Address step wraps naturally at the RAM size.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + 8'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy flags.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_push, i_push_data   write side (ignored when full)
//   i_pop                 read side (ignored when empty)
//   o_pop_data            head word (zero after reset)
//   o_full, o_empty       registered occupancy flags
//   o_count               registered occupancy, 0..DEPTH
// DEPTH must be a power of two, >= 2.
module sync_fifo #(
  parameter  int WIDTH = 24,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             wr_en_s, rd_en_s;

  assign wr_en_s = i_push && !full_q;
  assign rd_en_s = i_pop && !empty_q;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q] = i_push_data;
      wr_ptr_d        = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  assign o_pop_data = mem_q[rd_ptr_q];
  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_count    = count_q;

endmodule

// File: rtl/rgb_ram_reader.sv
// rgb_ram_reader: burst read initiator for the 256x24 RGB RAM.
// A block request (base, length) becomes a sequence of one-cycle read
// strobes, one outstanding at a time; returned words are queued in a
// sync_fifo and drained over a valid/ready pixel stream.
// Ports:
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_start, i_base_addr, i_len         block request (len 0..256)
//   o_busy, o_done                      burst in progress / completion pulse
//   o_read, o_read_addr                 RAM read strobe and address
//   i_rgb_data, i_rgb_valid             RAM response
//   o_pix_data, o_pix_valid, i_pix_ready  pixel stream
//   o_err                               sticky response-timeout flag
// Build option: define RGB_READER_TIMEOUT_EN to enable the response
// timeout (ERR_COLOR substituted, o_err set); otherwise o_err is 0.
module rgb_ram_reader
  import rgb_ram_pkg::*;
#(
  parameter int                DEPTH          = 4,
  parameter int                TIMEOUT_CYCLES = 15,
  parameter logic [DATA_W-1:0] ERR_COLOR      = ERR_COLOR_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_read,
  output logic [ADDR_W-1:0] o_read_addr,
  input  logic [DATA_W-1:0] i_rgb_data,
  input  logic              i_rgb_valid,
  output logic [DATA_W-1:0] o_pix_data,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic              o_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              read_q, read_d;

  logic              push_s;
  logic [DATA_W-1:0] push_data_s;
  logic              resp_s;
  logic              pop_s;
  logic              room_s;
  logic [CNT_W-1:0]  occ_next_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;

`ifdef RGB_READER_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
  logic       timeout_s;

  // WAIT cycles are counted from the strobe cycle onwards.
  assign timeout_s = (state_q == ST_WAIT) && !i_rgb_valid &&
                     (tmo_q == 8'(TIMEOUT_CYCLES - 1));
`endif

  assign pop_s = !fifo_empty_s && i_pix_ready;

  // Occupancy after this cycle's push; decides whether the next strobe can
  // follow the response directly (3-cycle cadence) or must wait in ISSUE.
  assign occ_next_s = fifo_count_s + CNT_W'(1) - CNT_W'(pop_s);
  assign room_s     = (occ_next_s < CNT_W'(DEPTH));

  // Next-state and registered-output logic for the burst sequencer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    read_d      = 1'b0;
    push_s      = 1'b0;
    push_data_s = i_rgb_data;
    resp_s      = i_rgb_valid;
`ifdef RGB_READER_TIMEOUT_EN
    err_d = err_q;
    tmo_d = tmo_q;
    if (timeout_s) begin
      resp_s      = 1'b1;
      push_data_s = ERR_COLOR;
    end else begin
      resp_s      = i_rgb_valid;
      push_data_s = i_rgb_data;
    end
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
`ifdef RGB_READER_TIMEOUT_EN
          err_d = 1'b0;
`endif
          if (i_len == 9'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            addr_d  = i_base_addr;
            cnt_d   = i_len;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!fifo_full_s) begin
          read_d  = 1'b1;
          state_d = ST_WAIT;
`ifdef RGB_READER_TIMEOUT_EN
          tmo_d = 8'd0;
`endif
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (resp_s) begin
          push_s = 1'b1;
          addr_d = next_addr(addr_q);
          cnt_d  = cnt_q - 9'd1;
`ifdef RGB_READER_TIMEOUT_EN
          if (!i_rgb_valid) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
`endif
          if (cnt_q == 9'd1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (room_s && !read_q) begin
            // Strobe the next address straight away; WAIT already gave
            // the required low cycle before it.
            read_d  = 1'b1;
            state_d = ST_WAIT;
`ifdef RGB_READER_TIMEOUT_EN
            tmo_d = 8'd0;
`endif
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_WAIT;
`ifdef RGB_READER_TIMEOUT_EN
          tmo_d = tmo_q + 8'd1;
`endif
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered control outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 8'd0;
      cnt_q   <= 9'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      read_q  <= read_d;
    end
  end

`ifdef RGB_READER_TIMEOUT_EN
  // Timeout counter and sticky error flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (push_s),
    .i_push_data (push_data_s),
    .i_pop       (pop_s),
    .o_pop_data  (o_pix_data),
    .o_full      (fifo_full_s),
    .o_empty     (fifo_empty_s),
    .o_count     (fifo_count_s)
  );

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_read      = read_q;
  assign o_read_addr = addr_q;
  assign o_pix_valid = !fifo_empty_s;

endmodule

// File: tb/tb_rgb_ram_reader.sv
// Directed bench for rgb_ram_reader with a 2-cycle-latency RAM responder
// and a stream consumer log.
module tb_rgb_ram_reader;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [7:0]  i_base_addr;
  logic [8:0]  i_len;
  logic        o_busy, o_done, o_read;
  logic [7:0]  o_read_addr;
  logic [23:0] i_rgb_data;
  logic        i_rgb_valid;
  logic [23:0] o_pix_data;
  logic        o_pix_valid;
  logic        i_pix_ready;
  logic        o_err;

  int          n_checks = 0;
  int          n_errors = 0;

  logic [7:0]  strobe_q [$];
  logic [23:0] pix_q [$];
  int          done_cnt = 0;
  int          gap_err = 0;
  logic        prev_read = 1'b0;

  logic        silent_en;
  logic [7:0]  silent_addr;

  rgb_ram_reader #(.DEPTH(4), .TIMEOUT_CYCLES(15), .ERR_COLOR(24'hFF00FF)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_len       (i_len),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_read      (o_read),
    .o_read_addr (o_read_addr),
    .i_rgb_data  (i_rgb_data),
    .i_rgb_valid (i_rgb_valid),
    .o_pix_data  (o_pix_data),
    .o_pix_valid (o_pix_valid),
    .i_pix_ready (i_pix_ready),
    .o_err       (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] exp_word(input logic [7:0] a);
    logic [7:0] hi;
    hi = a + 8'h10;
    return {8'hA0, a, hi};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RAM model: valid two cycles after the strobe, data derived from address.
  initial begin
    logic p1, p2;
    logic [7:0] a1, a2;
    p1 = 1'b0; p2 = 1'b0; a1 = 8'h00; a2 = 8'h00;
    i_rgb_valid = 1'b0;
    i_rgb_data  = 24'h0;
    forever begin
      @(negedge clk);
      i_rgb_valid = p2 && !(silent_en && (a2 == silent_addr));
      i_rgb_data  = p2 ? exp_word(a2) : 24'h0;
      p2 = p1;
      a2 = a1;
      p1 = o_read;
      a1 = o_read_addr;
    end
  end

  // Observer: strobes, popped words, done pulses, back-to-back strobes.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (o_read) strobe_q.push_back(o_read_addr);
      if (o_read && prev_read) gap_err++;
      prev_read = o_read;
      if (o_pix_valid && i_pix_ready) pix_q.push_back(o_pix_data);
      if (o_done) done_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_logs();
    strobe_q.delete();
    pix_q.delete();
    done_cnt = 0;
  endtask

  // Returns at the falling edge of the cycle after acceptance (cycle 0).
  task automatic start_burst(input logic [7:0] base, input logic [8:0] len);
    @(negedge clk);
    i_start = 1'b1; i_base_addr = base; i_len = len;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cyc);
    logic found;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < budget) begin
      if (o_done) found = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_done_seen"}, {31'd0, found}, 32'd1);
  endtask

  task automatic check_burst(input string tag, input logic [7:0] base, input int n);
    logic [7:0] a;
    check({tag, "_nstrobe"}, strobe_q.size(), n);
    check({tag, "_nword"}, pix_q.size(), n);
    for (int i = 0; i < n; i++) begin
      a = base + 8'(i);
      if (i < strobe_q.size()) check($sformatf("%s_addr%0d", tag, i), {24'd0, strobe_q[i]}, {24'd0, a});
      if (i < pix_q.size()) check($sformatf("%s_word%0d", tag, i), {8'd0, pix_q[i]}, {8'd0, exp_word(a)});
    end
  endtask

  initial begin
    int cyc;
    int n;
    rst_n = 1'b0; i_start = 1'b0; i_base_addr = 8'h00; i_len = 9'd0;
    i_pix_ready = 1'b1; silent_en = 1'b0; silent_addr = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_read", o_read, 0);
    check("rst_addr", o_read_addr, 0);
    check("rst_pvalid", o_pix_valid, 0);
    check("rst_pdata", o_pix_data, 0);
    check("rst_err", o_err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 3-word burst.
    clear_logs();
    start_burst(8'h10, 9'd3);
    check("t1_busy", o_busy, 1);
    wait_done("t1", 60, cyc);
    repeat (6) @(negedge clk);
    check_burst("t1", 8'h10, 3);
    check("t1_done_cnt", done_cnt, 1);

    // Address wrap and completion latency.
    clear_logs();
    start_burst(8'hFE, 9'd4);
    wait_done("t2", 60, cyc);
    check("t2_latency", cyc, 13);
    repeat (6) @(negedge clk);
    check_burst("t2", 8'hFE, 4);
    check("t2_busy_low", o_busy, 0);

    // Consumer stalled: FIFO fills after four strobes.
    clear_logs();
    i_pix_ready = 1'b0;
    start_burst(8'h20, 9'd6);
    n = 0;
    while (strobe_q.size() < 4 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (12) @(negedge clk);
    check("t3_stall_strobes", strobe_q.size(), 4);
    check("t3_stall_busy", o_busy, 1);
    check("t3_stall_pvalid", o_pix_valid, 1);
    i_pix_ready = 1'b1;
    wait_done("t3", 120, cyc);
    repeat (8) @(negedge clk);
    check_burst("t3", 8'h20, 6);

    // Zero-length request.
    clear_logs();
    start_burst(8'h33, 9'd0);
    check("t4_done", o_done, 1);
    check("t4_busy", o_busy, 0);
    @(negedge clk);
    check("t4_done_pulse", o_done, 0);
    repeat (3) @(negedge clk);
    check("t4_nstrobe", strobe_q.size(), 0);
    check("t4_done_cnt", done_cnt, 1);

    // Start while busy is ignored.
    clear_logs();
    start_burst(8'h40, 9'd2);
    repeat (2) @(negedge clk);
    i_start = 1'b1; i_base_addr = 8'h80; i_len = 9'd5;
    @(negedge clk);
    i_start = 1'b0;
    wait_done("t5", 60, cyc);
    repeat (6) @(negedge clk);
    check_burst("t5", 8'h40, 2);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_busy", o_busy, 0);

    // Reset during WAIT; the in-flight response must be dropped.
    clear_logs();
    start_burst(8'h60, 9'd3);
    n = 0;
    while (!o_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_strobe_seen", o_read, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_read", o_read, 0);
    check("t6_rst_addr", o_read_addr, 0);
    check("t6_rst_pvalid", o_pix_valid, 0);
    #2;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_late_pvalid", o_pix_valid, 0);
    check("t6_late_words", pix_q.size(), 0);
    check("t6_late_busy", o_busy, 0);

`ifdef RGB_READER_TIMEOUT_EN
    // Silent responder on one address: error colour pushed, error raised.
    clear_logs();
    silent_en = 1'b1; silent_addr = 8'h72;
    start_burst(8'h70, 9'd4);
    wait_done("t7", 150, cyc);
    repeat (6) @(negedge clk);
    check("t7_nword", pix_q.size(), 4);
    if (pix_q.size() == 4) begin
      check("t7_w0", pix_q[0], exp_word(8'h70));
      check("t7_w1", pix_q[1], exp_word(8'h71));
      check("t7_w2", pix_q[2], 24'hFF00FF);
      check("t7_w3", pix_q[3], exp_word(8'h73));
    end
    check("t7_err", o_err, 1);
    silent_en = 1'b0;
    start_burst(8'h90, 9'd1);
    check("t7_err_clr", o_err, 0);
    wait_done("t7b", 60, cyc);
`else
    check("t7_err_low", o_err, 0);
`endif

    check("gap_violations", gap_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
